// File: rtl/trdb_pkg.sv
// Shared types and sizes for the trace-encoder packet scheduler.
package trdb_pkg;

    localparam int BRANCH_MAP_LEN   = 31;
    localparam int BRANCH_COUNT_LEN = 5;
    localparam int PTYPE_LEN        = 3;

    typedef enum logic [PTYPE_LEN-1:0] {
        F0SF0 = 3'd0,
        F1    = 3'd1,
        F2    = 3'd2,
        F3SF0 = 3'd3,
        F3SF1 = 3'd4,
        F3SF2 = 3'd5,
        F3SF3 = 3'd6
    } it_packet_type_e;

    typedef enum logic {
        PACKET_MODE = 1'b0,
        CYCLE_MODE  = 1'b1
    } resync_mode_e;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        NEED_START = 2'd1,
        RUN        = 2'd2,
        HOLD       = 2'd3
    } sched_state_e;

endpackage

// File: rtl/trdb_packet_scheduler_if.sv
// Packet request channel between the scheduler (master) and the packet emitter (slave).
interface trdb_packet_scheduler_if;
    import trdb_pkg::*;

    logic                        pkt_valid;
    logic                        pkt_ready;
    it_packet_type_e             pkt_type;
    logic [BRANCH_MAP_LEN-1:0]   branch_map;
    logic [BRANCH_COUNT_LEN-1:0] branch_count;

    modport master (
        output pkt_valid,
        input  pkt_ready,
        output pkt_type,
        output branch_map,
        output branch_count
    );

    modport slave (
        input  pkt_valid,
        output pkt_ready,
        input  pkt_type,
        input  branch_map,
        input  branch_count
    );

endinterface

// File: rtl/trdb_resync_cnt.sv
// Resync counter: counts accepted packets or enabled cycles, saturates, flags when the threshold is reached.
module trdb_resync_cnt
    import trdb_pkg::*;
#(
    parameter resync_mode_e MODE = PACKET_MODE,
    parameter int           W    = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cycle_en,
    input  logic         pkt_accept,
    input  logic         clear,
    input  logic [W-1:0] resync_max,
    output logic         pending
);

    logic [W-1:0] cnt_q;
    logic         inc;

    assign inc = (MODE == CYCLE_MODE) ? cycle_en : pkt_accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A zero threshold disables resync entirely.
    assign pending = (resync_max != '0) && (cnt_q >= resync_max);

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Per retired instruction decides which trace packet to emit, accumulates the branch map
// and holds the selected packet across valid/ready backpressure.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   OFF        | trace disabled, nothing tracked
//   NEED_START | next instruction must produce an F3SF0 (sync) packet
//   RUN        | tracking, packets produced on demand
//   HOLD       | packet presented, waiting for the emitter to accept
module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter resync_mode_e RESYNC_MODE  = PACKET_MODE,
    parameter int           RESYNC_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    inst_valid_i,
    input  logic                    req_trap_i,
    input  logic                    req_context_i,
    input  logic                    req_support_i,
    input  logic                    req_addr_i,
    input  logic                    branch_i,
    input  logic                    branch_taken_i,
    input  logic [RESYNC_CNT_W-1:0] resync_max_i,
    trdb_packet_scheduler_if.master pkt,
    output logic                    stall_o,
    output logic                    lost_o
);

    sched_state_e                state_q;
    logic [BRANCH_MAP_LEN-1:0]   map_q, map_nxt, out_map_q;
    logic [BRANCH_COUNT_LEN-1:0] count_q, count_nxt, out_count_q;
    it_packet_type_e             out_type_q, emit_type;
    logic                        out_valid_q;
    logic                        lost_q;
    logic                        drop_seen_q;
    logic                        emit;
    logic                        force_start;
    logic                        accept;
    logic                        resync_pending;

    assign accept      = (state_q == HOLD) && pkt.pkt_ready;
    assign force_start = (state_q == NEED_START) || drop_seen_q;

    trdb_resync_cnt #(
        .MODE (RESYNC_MODE),
        .W    (RESYNC_CNT_W)
    ) u_resync_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cycle_en   (enable_i && (state_q != OFF)),
        .pkt_accept (accept),
        .clear      (accept && (out_type_q == F3SF0)),
        .resync_max (resync_max_i),
        .pending    (resync_pending)
    );

    // The current instruction's branch is folded in before selection so it lands in its own packet.
    always_comb begin
        map_nxt   = map_q;
        count_nxt = count_q;
        if (branch_i) begin
            map_nxt[count_q] = ~branch_taken_i;
            count_nxt        = count_q + 1'b1;
        end

        emit      = 1'b1;
        emit_type = F0SF0;
        if (force_start)                                 emit_type = F3SF0;
        else if (req_trap_i)                             emit_type = F3SF1;
        else if (resync_pending)                         emit_type = F3SF0;
        else if (req_context_i)                          emit_type = F3SF2;
        else if (req_support_i)                          emit_type = F3SF3;
        else if (req_addr_i)                             emit_type = (count_nxt != '0) ? F1 : F2;
        else if (count_nxt == BRANCH_COUNT_LEN'(BRANCH_MAP_LEN)) emit_type = F1;
        else                                             emit = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= OFF;
            map_q       <= '0;
            count_q     <= '0;
            out_map_q   <= '0;
            out_count_q <= '0;
            out_type_q  <= F0SF0;
            out_valid_q <= 1'b0;
            lost_q      <= 1'b0;
            drop_seen_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (enable_i) state_q <= NEED_START;
                end
                NEED_START, RUN: begin
                    if (!enable_i) begin
                        state_q <= OFF;
                        map_q   <= '0;
                        count_q <= '0;
                    end else if (inst_valid_i) begin
                        if (emit) begin
                            out_valid_q <= 1'b1;
                            out_type_q  <= emit_type;
                            out_map_q   <= map_nxt;
                            out_count_q <= count_nxt;
                            map_q       <= '0;
                            count_q     <= '0;
                            state_q     <= HOLD;
                        end else begin
                            map_q   <= map_nxt;
                            count_q <= count_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (pkt.pkt_ready) begin
                        out_valid_q <= 1'b0;
                        drop_seen_q <= 1'b0;
                        if (out_type_q == F3SF0) lost_q <= 1'b0;
                        if (!enable_i) begin
                            state_q <= OFF;
                            map_q   <= '0;
                            count_q <= '0;
                        end else if (inst_valid_i && emit) begin
                            out_valid_q <= 1'b1;
                            out_type_q  <= emit_type;
                            out_map_q   <= map_nxt;
                            out_count_q <= count_nxt;
                            map_q       <= '0;
                            count_q     <= '0;
                        end else begin
                            if (inst_valid_i) begin
                                map_q   <= map_nxt;
                                count_q <= count_nxt;
                            end
                            state_q <= drop_seen_q ? NEED_START : RUN;
                        end
                    end else if (inst_valid_i) begin
                        lost_q      <= 1'b1;
                        drop_seen_q <= 1'b1;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    assign pkt.pkt_valid    = out_valid_q;
    assign pkt.pkt_type     = out_type_q;
    assign pkt.branch_map   = out_map_q;
    assign pkt.branch_count = out_count_q;
    assign stall_o          = (state_q == HOLD) && !pkt.pkt_ready;
    assign lost_o           = lost_q;

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed bench for trdb_packet_scheduler: vector table plus multi-cycle corner sequences.
module tb_trdb_packet_scheduler;
    import trdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        inst_valid, req_trap, req_context, req_support, req_addr;
    logic        branch, branch_taken;
    logic [15:0] resync_max;
    logic        stall, lost;

    trdb_packet_scheduler_if pkt_if ();

    trdb_packet_scheduler #(
        .RESYNC_MODE  (PACKET_MODE),
        .RESYNC_CNT_W (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .inst_valid_i   (inst_valid),
        .req_trap_i     (req_trap),
        .req_context_i  (req_context),
        .req_support_i  (req_support),
        .req_addr_i     (req_addr),
        .branch_i       (branch),
        .branch_taken_i (branch_taken),
        .resync_max_i   (resync_max),
        .pkt            (pkt_if.master),
        .stall_o        (stall),
        .lost_o         (lost)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic            inst, br, tk, trap, ctx, sup, addr;
        logic            e_valid;
        it_packet_type_e e_type;
        logic [30:0]     e_map;
        logic [4:0]      e_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic inst, br, tk, trap, ctx, sup, addr, e_valid,
                                input it_packet_type_e e_type, input logic [30:0] e_map,
                                input logic [4:0] e_cnt);
        vec_t v;
        v.inst = inst; v.br = br; v.tk = tk; v.trap = trap; v.ctx = ctx; v.sup = sup;
        v.addr = addr; v.e_valid = e_valid; v.e_type = e_type; v.e_map = e_map; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic inst, br, tk, trap, ctx, sup, addr);
        inst_valid = inst; branch = br; branch_taken = tk;
        req_trap = trap; req_context = ctx; req_support = sup; req_addr = addr;
    endtask

    task automatic chk_pkt(input string name, input logic e_valid, input it_packet_type_e e_type,
                           input logic [30:0] e_map, input logic [4:0] e_cnt);
        chk({name, ".valid"}, 32'(pkt_if.pkt_valid), 32'(e_valid));
        chk({name, ".type"},  32'(pkt_if.pkt_type), 32'(e_type));
        chk({name, ".map"},   32'(pkt_if.branch_map), 32'(e_map));
        chk({name, ".count"}, 32'(pkt_if.branch_count), 32'(e_cnt));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; resync_max = 16'd0; pkt_if.pkt_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        //                inst br tk trap ctx sup addr  valid type   map     cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, F3SF0, 31'd0, 5'd0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, F3SF0, 31'd0, 5'd0);
        vecs[2]  = mk(1, 1, 1, 0, 0, 0, 0, 0, F3SF0, 31'd0, 5'd0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, F3SF0, 31'd0, 5'd0);
        vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0, 0, F3SF0, 31'd0, 5'd0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 1, 1, F1,    31'b010, 5'd3);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 1, F2,    31'd0, 5'd0);
        vecs[7]  = mk(1, 0, 0, 1, 1, 0, 1, 1, F3SF1, 31'd0, 5'd0);
        vecs[8]  = mk(1, 0, 0, 0, 1, 0, 0, 1, F3SF2, 31'd0, 5'd0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0, 1, F3SF3, 31'd0, 5'd0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, F3SF3, 31'd0, 5'd0);
        vecs[11] = mk(1, 1, 0, 0, 1, 0, 0, 1, F3SF2, 31'd1, 5'd1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, F3SF2, 31'd1, 5'd1);

        step(); step();
        chk_pkt("reset", 1'b0, F0SF0, 31'd0, 5'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.lost", 32'(lost), 32'd0);

        rst = 1'b0; enable = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].inst, vecs[i].br, vecs[i].tk, vecs[i].trap, vecs[i].ctx,
                  vecs[i].sup, vecs[i].addr);
            step();
            chk_pkt($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_type, vecs[i].e_map, vecs[i].e_cnt);
            chk($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
        end

        // 31 alternating branches fill the map and force F1 on the last one
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, logic'(i % 2), 0, 0, 0, 0);
            step();
            if (i < 30) chk($sformatf("fill%0d.valid", i), 32'(pkt_if.pkt_valid), 32'd0);
        end
        chk_pkt("fill_full", 1'b1, F1, 31'h55555555, 5'd31);
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        chk("fill_after.valid", 32'(pkt_if.pkt_valid), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        chk_pkt("fill_restart", 1'b1, F1, 31'd1, 5'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // backpressure with a dropped instruction
        drive(1, 0, 0, 0, 1, 0, 0);
        step();
        chk_pkt("stall_load", 1'b1, F3SF2, 31'd0, 5'd0);
        pkt_if.pkt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(logic'(k == 1), 1, 0, 0, 0, 0, 0);
            step();
            chk_pkt($sformatf("stall%0d", k), 1'b1, F3SF2, 31'd0, 5'd0);
            chk($sformatf("stall%0d.stall", k), 32'(stall), 32'd1);
            if (k >= 1) chk($sformatf("stall%0d.lost", k), 32'(lost), 32'd1);
        end
        pkt_if.pkt_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("drain.valid", 32'(pkt_if.pkt_valid), 32'd0);
        chk("drain.lost", 32'(lost), 32'd1);
        drive(1, 1, 1, 0, 0, 0, 0);
        step();
        chk_pkt("resync_after_drop", 1'b1, F3SF0, 31'd0, 5'd1);
        chk("resync_after_drop.lost", 32'(lost), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("lost_cleared", 32'(lost), 32'd0);

        // packet-mode resync after 4 accepted packets
        resync_max = 16'd4;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0, 0, 1);
            step();
            chk_pkt($sformatf("rs_f2_%0d", k), 1'b1, F2, 31'd0, 5'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_pkt("rs_fire", 1'b1, F3SF0, 31'd0, 5'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("rs_cleared.valid", 32'(pkt_if.pkt_valid), 32'd0);

        resync_max = 16'd0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0, 0, 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("rs_disabled.valid", 32'(pkt_if.pkt_valid), 32'd0);

        // enable drop clears the partial map and restarts with a sync packet
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_pkt("reenable", 1'b1, F3SF0, 31'd0, 5'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // reset while holding a packet
        drive(1, 0, 0, 0, 1, 0, 0);
        step();
        chk("rst_hold.pre", 32'(pkt_if.pkt_valid), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        pkt_if.pkt_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_hold.valid", 32'(pkt_if.pkt_valid), 32'd0);
        chk("rst_hold.stall", 32'(stall), 32'd0);
        chk("rst_hold.type", 32'(pkt_if.pkt_type), 32'(F0SF0));
        rst = 1'b0;
        pkt_if.pkt_ready = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_off.valid", 32'(pkt_if.pkt_valid), 32'd0);
        step();
        chk_pkt("rst_restart", 1'b1, F3SF0, 31'd0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
